// File: rtl/selector_bist.sv
// Self-test engine for the OR/AND selector: drives corner and LFSR operand
// pairs, samples the selector result after a fixed latency, tallies mismatches.
module selector_bist #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned LATENCY     = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    input  logic [7:0]  dut_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] first_fail_idx,
    output logic        first_fail_valid
);

    localparam int unsigned NV       = (NUM_VECTORS < 4) ? 4 : NUM_VECTORS;
    localparam logic [15:0] LAST_IDX = 16'(NV - 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam bit          NO_WAIT  = (LATENCY == 0);
    localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [7:0]  exp_q, exp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  err_q, err_d;
    logic [15:0] ffi_q, ffi_d;
    logic        ffv_q, ffv_d;

    logic [15:0] load_idx;
    logic [7:0]  vec_a;
    logic [7:0]  vec_b;
    logic        mismatch;
    logic [7:0]  err_inc;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] golden(input logic [7:0] a,
                                          input logic [7:0] b);
        return a[7] ? (a | b) : (a & b);
    endfunction

    // Index of the vector loaded on this edge: 0 on start, idx+1 on advance.
    always_comb begin
        load_idx = (state_q == S_CHECK) ? idx_q + 16'd1 : 16'd0;
        vec_a    = lfsr_q[15:8];
        vec_b    = lfsr_q[7:0];
        case (load_idx)
            16'd0: begin vec_a = 8'h00; vec_b = 8'h00; end
            16'd1: begin vec_a = 8'hFF; vec_b = 8'hAA; end
            16'd2: begin vec_a = 8'h14; vec_b = 8'h1E; end
            16'd3: begin vec_a = 8'h94; vec_b = 8'h1E; end
            default: ;
        endcase
    end

    assign mismatch = (dut_result != exp_q);
    assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        wait_d  = wait_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        if (ena) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_d   = 8'd0;
                        ffi_d   = 16'd0;
                        ffv_d   = 1'b0;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        idx_d   = 16'd0;
                        lfsr_d  = SEED_EFF;
                        op_a_d  = vec_a;
                        op_b_d  = vec_b;
                        exp_d   = golden(vec_a, vec_b);
                        busy_d  = 1'b1;
                        wait_d  = WAIT_INIT;
                        state_d = NO_WAIT ? S_CHECK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        wait_d = wait_q - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_d = err_inc;
                        if (!ffv_q) begin
                            ffi_d = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == 8'd0) && !mismatch;
                    end else begin
                        idx_d   = load_idx;
                        op_a_d  = vec_a;
                        op_b_d  = vec_b;
                        exp_d   = golden(vec_a, vec_b);
                        wait_d  = WAIT_INIT;
                        state_d = NO_WAIT ? S_CHECK : S_WAIT;
                        if (load_idx >= 16'd4) begin
                            lfsr_d = lfsr_step(lfsr_q);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 16'd0;
            lfsr_q  <= SEED_EFF;
            wait_q  <= 4'd0;
            op_a_q  <= 8'd0;
            op_b_q  <= 8'd0;
            exp_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'd0;
            ffi_q   <= 16'd0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            wait_q  <= wait_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    assign op_a             = op_a_q;
    assign op_b             = op_b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_selector_bist.sv
// Bench for selector_bist: four instances with different sizes/latencies,
// each fed by a selectable golden, faulty, registered or randomly-broken selector.
module tb_selector_bist;

    logic clk;
    logic rst_n;
    logic [3:0]        start;
    logic [3:0]        ena;
    logic [3:0]        busy;
    logic [3:0]        done;
    logic [3:0]        pass;
    logic [3:0]        ffv;
    logic [3:0][7:0]   op_a;
    logic [3:0][7:0]   op_b;
    logic [3:0][7:0]   errc;
    logic [3:0][7:0]   dres;
    logic [3:0][7:0]   reg_res;
    logic [3:0][15:0]  ffi;

    int mode [4];
    logic [7:0] flip_tbl [256];

    localparam int NVS [4]          = '{8, 300, 6, 4};
    localparam int LATS [4]         = '{0, 0, 1, 0};
    localparam logic [15:0] SEEDS [4] = '{16'hACE1, 16'hACE1, 16'h0000, 16'hACE1};

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] model_v [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    selector_bist #(.NUM_VECTORS(8), .LATENCY(0), .SEED(16'hACE1)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena[0]), .start(start[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .dut_result(dres[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_fail_idx(ffi[0]),
        .first_fail_valid(ffv[0]));

    selector_bist #(.NUM_VECTORS(300), .LATENCY(0), .SEED(16'hACE1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[1]), .start(start[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .dut_result(dres[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_fail_idx(ffi[1]),
        .first_fail_valid(ffv[1]));

    selector_bist #(.NUM_VECTORS(6), .LATENCY(1), .SEED(16'h0000)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena[2]), .start(start[2]),
        .op_a(op_a[2]), .op_b(op_b[2]), .dut_result(dres[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(errc[2]), .first_fail_idx(ffi[2]),
        .first_fail_valid(ffv[2]));

    selector_bist #(.NUM_VECTORS(2), .LATENCY(0), .SEED(16'hACE1)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena[3]), .start(start[3]),
        .op_a(op_a[3]), .op_b(op_b[3]), .dut_result(dres[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_count(errc[3]), .first_fail_idx(ffi[3]),
        .first_fail_valid(ffv[3]));

    function automatic logic [7:0] gold(input logic [7:0] a, input logic [7:0] b);
        return a[7] ? (a | b) : (a & b);
    endfunction

    // Selector models: 0 golden, 1 AND-only, 2 inverted, 3 one flop deep, 4 random flips
    always_comb begin
        dres = '0;
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                0: dres[i] = gold(op_a[i], op_b[i]);
                1: dres[i] = op_a[i] & op_b[i];
                2: dres[i] = ~gold(op_a[i], op_b[i]);
                3: dres[i] = reg_res[i];
                default: dres[i] = gold(op_a[i], op_b[i]) ^ flip_tbl[op_a[i]];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) reg_res[i] <= gold(op_a[i], op_b[i]);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_model(input int i);
        logic [15:0] fixed [4];
        logic [15:0] lf;
        fixed = '{16'h0000, 16'hFFAA, 16'h141E, 16'h941E};
        lf = (SEEDS[i] == 16'h0) ? 16'h0001 : SEEDS[i];
        model_v.delete();
        for (int j = 0; j < NVS[i]; j++) begin
            if (j < 4) model_v.push_back(fixed[j]);
            else begin
                model_v.push_back(lf);
                lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            end
        end
    endtask

    task automatic run_case(input int i, input int e_err, input int e_ffi,
                            input int e_ffv, input int e_pass,
                            input bit pass_only, input string tag);
        logic [15:0] got [$];
        int k;
        int lat1;
        int budget;
        lat1 = LATS[i] + 1;
        budget = NVS[i] * lat1 + 20;
        build_model(i);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        k = 0;
        while (busy[i] && k < budget) begin
            if (k % lat1 == 0) got.push_back({op_a[i], op_b[i]});
            k++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, k, NVS[i] * lat1);
        chk({tag, "_done"}, int'(done[i]), 1);
        chk({tag, "_pass"}, int'(pass[i]), e_pass);
        if (!pass_only) begin
            for (int j = 0; j < NVS[i]; j++)
                chk($sformatf("%s_op%0d", tag, j),
                    (j < got.size()) ? int'(got[j]) : -1, int'(model_v[j]));
            chk({tag, "_op_hold"}, int'({op_a[i], op_b[i]}),
                int'(model_v[NVS[i] - 1]));
            chk({tag, "_err"}, int'(errc[i]), e_err);
            chk({tag, "_ffi"}, int'(ffi[i]), e_ffi);
            chk({tag, "_ffv"}, int'(ffv[i]), e_ffv);
        end
    endtask

    typedef struct {
        int inst;
        int md;
        int err;
        int ffi;
        int ffv;
        int pass;
        bit pass_only;
    } vec_t;

    initial begin
        vec_t tbl [7];
        logic [7:0] a0;
        logic [7:0] e0;
        int cnt;
        int first;
        tbl[0] = '{0, 0, 0,   0, 0, 1, 1'b0};
        tbl[1] = '{3, 1, 2,   1, 1, 0, 1'b0};
        tbl[2] = '{0, 1, 4,   1, 1, 0, 1'b0};
        tbl[3] = '{1, 2, 255, 0, 1, 0, 1'b0};
        tbl[4] = '{2, 3, 0,   0, 0, 1, 1'b0};
        tbl[5] = '{0, 3, 0,   0, 0, 0, 1'b1};
        tbl[6] = '{0, 0, 0,   0, 0, 1, 1'b0};

        for (int i = 0; i < 4; i++) mode[i] = 0;
        for (int x = 0; x < 256; x++) flip_tbl[x] = 8'h00;
        start = '0;
        ena   = '1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_outs%0d", i),
                int'({op_a[i], op_b[i], errc[i]}) | int'(ffi[i]) |
                int'({busy[i], done[i], pass[i], ffv[i]}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            mode[tbl[t].inst] = tbl[t].md;
            run_case(tbl[t].inst, tbl[t].err, tbl[t].ffi, tbl[t].ffv,
                     tbl[t].pass, tbl[t].pass_only, $sformatf("tbl%0d", t));
        end

        // Pause five cycles mid-run with a start held; another start while running.
        mode[0] = 1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cnt = 0;
        a0 = '0;
        e0 = '0;
        for (int s = 0; s < 25; s++) begin
            if (busy[0]) cnt++;
            if (s == 3) begin
                a0 = op_a[0];
                e0 = errc[0];
                chk("frz_opa_at_pause", int'(a0), 'h94);
                chk("frz_err_at_pause", int'(e0), 1);
                ena[0] = 1'b0;
                start[0] = 1'b1;
            end else if (s >= 4 && s <= 8) begin
                chk($sformatf("frz_opa%0d", s), int'(op_a[0]), int'(a0));
                chk($sformatf("frz_err%0d", s), int'(errc[0]), int'(e0));
                if (s == 8) begin
                    ena[0] = 1'b1;
                    start[0] = 1'b0;
                end
            end else if (s == 10) begin
                start[0] = 1'b1;
            end else if (s == 11) begin
                start[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("frz_busy_cycles", cnt, 13);
        chk("frz_done", int'(done[0]), 1);
        chk("frz_err", int'(errc[0]), 4);
        chk("frz_ffi", int'(ffi[0]), 1);
        chk("frz_pass", int'(pass[0]), 0);
        chk("frz_last_opa", int'(op_a[0]), 'h38);

        // Asynchronous reset between edges, then a clean rerun.
        mode[0] = 0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_busy", int'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", int'(busy[0]), 0);
        chk("rst_async_ops", int'({op_a[0], op_b[0]}), 0);
        chk("rst_async_res", int'({errc[0], done[0], pass[0], ffv[0]}) | int'(ffi[0]), 0);
        chk("rst_async_done1", int'(done[1]), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(0, 0, 0, 0, 1, 1'b0, "after_rst");

        // Random per-operand corruption on the long instance.
        mode[1] = 4;
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < 256; x++)
                flip_tbl[x] = ($urandom_range(0, 3) == 0) ?
                              8'($urandom_range(1, 255)) : 8'h00;
            build_model(1);
            cnt = 0;
            first = -1;
            for (int j = 0; j < NVS[1]; j++) begin
                if (flip_tbl[model_v[j][15:8]] != 8'h00) begin
                    cnt++;
                    if (first < 0) first = j;
                end
            end
            run_case(1, (cnt > 255) ? 255 : cnt, (first < 0) ? 0 : first,
                     (cnt > 0) ? 1 : 0, (cnt == 0) ? 1 : 0, 1'b0,
                     $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
